// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux_rr
// Description : N-to-1 streaming multiplexer with per-channel valid/ready
//               handshakes, fixed-select or round-robin arbitration and a
//               single registered output beat (1-cycle latency, full rate).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   i_mode       0 = fixed select via i_sel, 1 = round-robin
//   i_sel        channel index used in fixed mode
//   i_in_data    packed channel data, channel i at [i*DATA_W +: DATA_W]
//   i_in_valid   per-channel valid
//   o_in_ready   per-channel ready (combinational, at most one bit set)
//   o_out_data   registered output data
//   o_out_valid  registered output valid
//   i_out_ready  consumer ready
//   o_out_ch     index of the channel that sourced o_out_data
// ============================================================================
module stream_mux_rr #(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_mode,
    input  logic [SEL_W-1:0]         i_sel,
    input  logic [NUM_CH*DATA_W-1:0] i_in_data,
    input  logic [NUM_CH-1:0]        i_in_valid,
    output logic [NUM_CH-1:0]        o_in_ready,
    output logic [DATA_W-1:0]        o_out_data,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [SEL_W-1:0]         o_out_ch
);

    // One extra bit so that pointer + offset never overflows before the
    // modulo-NUM_CH wrap, and so that out-of-range selects can be detected
    // for non-power-of-2 channel counts.
    localparam int                 IDX_W    = SEL_W + 1;
    localparam logic [IDX_W-1:0]   C_NUM_CH = IDX_W'(NUM_CH);
    localparam logic [SEL_W-1:0]   C_PTR_RST = SEL_W'(NUM_CH - 1);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_out_data;
    logic [SEL_W-1:0]  r_out_ch;
    logic [SEL_W-1:0]  r_rr_ptr;

    logic              w_can_load;
    logic              w_fix_hit;
    logic              w_rr_hit;
    logic [SEL_W-1:0]  w_rr_ch;
    logic [IDX_W-1:0]  w_scan_idx;
    logic              w_hit;
    logic [SEL_W-1:0]  w_chosen;
    logic [DATA_W-1:0] w_chosen_data;
    logic              w_chosen_valid;
    logic              w_in_xfer;

    // The output register can take a new beat when it is empty or when its
    // current beat leaves in this same cycle.
    assign w_can_load = (r_state == ST_EMPTY) | i_out_ready;

    // Fixed mode: a select beyond the last channel chooses nothing.
    assign w_fix_hit = ({1'b0, i_sel} < C_NUM_CH);

    // Round-robin scan: start one past the last served channel and take the
    // first valid one, wrapping modulo NUM_CH.
    always_comb begin
        w_rr_hit   = 1'b0;
        w_rr_ch    = '0;
        w_scan_idx = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_scan_idx = {1'b0, r_rr_ptr} + IDX_W'(k + 1);
            if (w_scan_idx >= C_NUM_CH) begin
                w_scan_idx = w_scan_idx - C_NUM_CH;
            end
            if (!w_rr_hit && i_in_valid[w_scan_idx[SEL_W-1:0]]) begin
                w_rr_hit = 1'b1;
                w_rr_ch  = w_scan_idx[SEL_W-1:0];
            end
        end
    end

    // Mode is applied combinationally; a switch takes effect immediately.
    assign w_hit    = i_mode ? w_rr_hit : w_fix_hit;
    assign w_chosen = i_mode ? w_rr_ch  : i_sel;

    // Data/valid mux written as a compare loop so that an out-of-range
    // chosen index simply matches nothing.
    always_comb begin
        w_chosen_data  = '0;
        w_chosen_valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_chosen == SEL_W'(i)) begin
                w_chosen_data  = i_in_data[i*DATA_W +: DATA_W];
                w_chosen_valid = i_in_valid[i];
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ready
            assign o_in_ready[g] = w_can_load & w_hit & (w_chosen == SEL_W'(g));
        end
    endgenerate

    assign w_in_xfer = w_can_load & w_hit & w_chosen_valid;

    // Output register and arbitration pointer. The pointer only moves on
    // round-robin transfers so fixed-mode traffic does not disturb fairness.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_out_data <= '0;
            r_out_ch   <= '0;
            r_rr_ptr   <= C_PTR_RST;
        end else begin
            if (w_in_xfer) begin
                r_out_data <= w_chosen_data;
                r_out_ch   <= w_chosen;
                if (i_mode) begin
                    r_rr_ptr <= w_chosen;
                end
            end
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        r_state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    // Reload keeps the register full; a bare drain empties it.
                    if (!w_in_xfer && i_out_ready) begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    assign o_out_data  = r_out_data;
    assign o_out_ch    = r_out_ch;
    assign o_out_valid = (r_state == ST_FULL);

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_mux_rr
// Description : Scoreboard bench for stream_mux_rr. A reference model built
//               from the arbitration rules predicts each accepted beat and
//               queues it; an independent monitor pops and compares every
//               beat the DUT hands to the consumer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_mux_rr;

    localparam int NC = 4;
    localparam int DW = 8;

    logic            clk;
    logic            rst_n;
    logic            mode;
    logic [1:0]      sel;
    logic [NC*DW-1:0] in_data;
    logic [NC-1:0]   in_valid;
    logic [NC-1:0]   in_ready;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      out_ch;

    // Three-channel instance for the out-of-range select case.
    logic            mode3;
    logic [1:0]      sel3;
    logic [3*DW-1:0] in_data3;
    logic [2:0]      in_valid3;
    logic [2:0]      in_ready3;
    logic [DW-1:0]   out_data3;
    logic            out_valid3;
    logic            out_ready3;
    logic [1:0]      out_ch3;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit        m_full;
    int        m_ptr;
    logic [9:0] q[$];

    stream_mux_rr #(.NUM_CH(NC), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .i_mode(mode), .i_sel(sel),
        .i_in_data(in_data), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .o_out_data(out_data), .o_out_valid(out_valid),
        .i_out_ready(out_ready), .o_out_ch(out_ch)
    );

    stream_mux_rr #(.NUM_CH(3), .DATA_W(DW)) dut3 (
        .clk(clk), .rst_n(rst_n), .i_mode(mode3), .i_sel(sel3),
        .i_in_data(in_data3), .i_in_valid(in_valid3), .o_in_ready(in_ready3),
        .o_out_data(out_data3), .o_out_valid(out_valid3),
        .i_out_ready(out_ready3), .o_out_ch(out_ch3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which channel the rules pick; -1 means none.
    function automatic int choose(input bit md, input int s, input logic [NC-1:0] v, input int ptr);
        if (!md) return (s < NC) ? s : -1;
        for (int k = 1; k <= NC; k++) begin
            int c;
            c = (ptr + k) % NC;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // One cycle: drive inputs after the falling edge, check the
    // combinational ready and the output valid, then advance the model.
    task automatic step(input bit md, input logic [1:0] sl, input logic [NC-1:0] v,
                        input logic [NC*DW-1:0] d, input bit ordy);
        bit         can;
        int         c;
        logic [NC-1:0] exp_rdy;
        @(negedge clk);
        mode = md; sel = sl; in_valid = v; in_data = d; out_ready = ordy;
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_full});
        can = !m_full || ordy;
        c = choose(md, int'(sl), v, m_ptr);
        exp_rdy = (can && c >= 0) ? NC'(1 << c) : '0;
        chk("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
        if (can && c >= 0 && v[c]) begin
            q.push_back({2'(c), d[c*DW +: DW]});
            m_full = 1'b1;
            if (md) m_ptr = c;
        end else if (m_full && ordy) begin
            m_full = 1'b0;
        end
    endtask

    task automatic rnd_step();
        step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
             NC'($urandom), $urandom, ($urandom_range(0, 3) != 0));
    endtask

    // Monitor: a beat leaves when valid and ready are both high at the edge.
    initial begin
        logic [9:0] exp_beat;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", {22'd0, out_ch, out_data}, 32'hFFFF_FFFF);
                end else begin
                    exp_beat = q.pop_front();
                    chk("beat_ch", {30'd0, out_ch}, {30'd0, exp_beat[9:8]});
                    chk("beat_data", {24'd0, out_data}, {24'd0, exp_beat[7:0]});
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; mode = 1'b0; sel = '0; in_data = '0; in_valid = '0; out_ready = 1'b0;
        mode3 = 1'b0; sel3 = '0; in_data3 = '0; in_valid3 = '0; out_ready3 = 1'b0;
        m_full = 1'b0; m_ptr = NC - 1;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_out_ch", {30'd0, out_ch}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin from power-up: first beat from channel 0
        for (int i = 0; i < 8; i++) step(1'b1, 2'd0, 4'b1111, $urandom, 1'b1);
        // Only channel 3 valid
        for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 4'b1000, $urandom, 1'b1);
        // Fixed select of channel 2, continuous stream
        for (int i = 0; i < 4; i++) step(1'b0, 2'd2, 4'b1111, 32'hD3C2B1A0, 1'b1);
        // Backpressure: hold for 3 cycles, then reload with no bubble
        for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 4'b1111, $urandom, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 4'b1111, $urandom, 1'b1);
        // Mode switch: fixed sel=3 for two beats, then back to round-robin
        for (int i = 0; i < 2; i++) step(1'b0, 2'd3, 4'b1111, $urandom, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 4'b1111, $urandom, 1'b1);

        for (int i = 0; i < 400; i++) rnd_step();

        // Mid-stream asynchronous reset with a beat held
        step(1'b1, 2'd0, 4'b1111, $urandom, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_out_data", {24'd0, out_data}, 32'd0);
        chk("midrst_out_ch", {30'd0, out_ch}, 32'd0);
        q.delete();
        m_full = 1'b0; m_ptr = NC - 1;
        in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 4'b1111, $urandom, 1'b1);
        for (int i = 0; i < 200; i++) rnd_step();

        // Drain and confirm every predicted beat was delivered
        for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 4'b0000, 32'd0, 1'b1);
        chk("queue_empty", q.size(), 32'd0);

        // Three-channel instance: out-of-range select chooses nothing
        @(negedge clk);
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
        in_data3 = 24'h332211;
        #1;
        chk("nc3_oor_ready", {29'd0, in_ready3}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk("nc3_oor_valid", {31'd0, out_valid3}, 32'd0);
            chk("nc3_oor_ready_hold", {29'd0, in_ready3}, 32'd0);
        end
        sel3 = 2'd2;
        #1;
        chk("nc3_sel2_ready", {29'd0, in_ready3}, 32'd4);
        @(negedge clk);
        in_valid3 = 3'b011; mode3 = 1'b1;
        #1;
        chk("nc3_sel2_valid", {31'd0, out_valid3}, 32'd1);
        chk("nc3_sel2_ch", {30'd0, out_ch3}, 32'd2);
        chk("nc3_sel2_data", {24'd0, out_data3}, 32'h33);
        // Pointer still at its reset value (2): scan starts at channel 0
        chk("nc3_rr_ready", {29'd0, in_ready3}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
